// File: rtl/prog_clock_div.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_div
// Purpose  : Fully synchronous, runtime-programmable clock divider. Produces a
//            registered divided square wave and a one-cycle tick enable, with
//            a glitch-free, period-aligned divisor reload handshake.
// Revision : 1.0 - initial release
//
// Ports    : clk          single system clock, rising edge
//            rst          synchronous active-high reset
//            en           count enable (low freezes the divider)
//            div_in       requested divisor N (values below 2 stored as 2)
//            div_load     one-cycle strobe capturing div_in
//            div_pending  a captured divisor waits to be applied
//            div_cur      divisor currently in effect
//            out          divided clock, high for ceil(N/2) of N cycles
//            tick         one-cycle pulse in the last cycle of each period
//            tick_cnt     running tick count (zero unless the option is on)
//
// Option   : PROG_CLOCK_DIV_TICK_CNT_EN - when defined, tick_cnt is a real
//            wrapping counter; otherwise the port is tied to 0.
// ============================================================================
module prog_clock_div #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 128,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_pending,
  output logic [WIDTH-1:0] div_cur,
  output logic             out,
  output logic             tick,
  output logic [CNT_W-1:0] tick_cnt
);

  localparam logic [WIDTH-1:0] C_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] C_MIN_DIV     = WIDTH'(2);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend_val;

  logic [WIDTH-1:0] cnt_nx;
  logic [WIDTH-1:0] div_nx;
  logic [WIDTH-1:0] pend_val_nx;
  logic             pend_nx;
  logic             out_nx;
  logic             tick_nx;
  logic [WIDTH-1:0] div_clamped;
  logic             last;

  assign div_clamped = (div_in < C_MIN_DIV) ? C_MIN_DIV : div_in;
  assign last        = (cnt == div_cur - 1'b1);

  always_comb begin
    cnt_nx      = cnt;
    div_nx      = div_cur;
    pend_val_nx = pend_val;
    pend_nx     = div_pending;
    out_nx      = out;
    tick_nx     = 1'b0;

    if (en) begin
      if (last) begin
        // Wrap edge: the only point where a new divisor may take effect
        // while running, so the old period always completes. A load in
        // this very cycle beats any older pending value.
        cnt_nx = '0;
        if (div_load) begin
          div_nx  = div_clamped;
          pend_nx = 1'b0;
        end else if (div_pending) begin
          div_nx  = pend_val;
          pend_nx = 1'b0;
        end
      end else begin
        cnt_nx = cnt + 1'b1;
        if (div_load) begin
          pend_val_nx = div_clamped;
          pend_nx     = 1'b1;
        end
      end
      // Outputs are decoded from the next state so the flops line up with cnt.
      out_nx  = (cnt_nx >= (div_nx >> 1));
      tick_nx = (cnt_nx == div_nx - 1'b1);
    end else begin
      // Frozen: a fresh load is captured first (last one wins); an already
      // pending value is applied immediately, restarting from phase 0.
      if (div_load) begin
        pend_val_nx = div_clamped;
        pend_nx     = 1'b1;
      end else if (div_pending) begin
        div_nx  = pend_val;
        pend_nx = 1'b0;
        cnt_nx  = '0;
        out_nx  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      div_cur     <= C_DEFAULT_DIV;
      pend_val    <= '0;
      div_pending <= 1'b0;
      out         <= 1'b0;
      tick        <= 1'b0;
    end else begin
      cnt         <= cnt_nx;
      div_cur     <= div_nx;
      pend_val    <= pend_val_nx;
      div_pending <= pend_nx;
      out         <= out_nx;
      tick        <= tick_nx;
    end
  end

`ifdef PROG_CLOCK_DIV_TICK_CNT_EN
  logic [CNT_W-1:0] tick_cnt_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r <= '0;
    end else if (en && tick) begin
      tick_cnt_r <= tick_cnt_r + 1'b1;
    end
  end

  assign tick_cnt = tick_cnt_r;
`else
  assign tick_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_clock_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_clock_div
// Purpose  : Self-checking bench for prog_clock_div. A behavioural model of
//            the divider phase is compared against the DUT every cycle, and
//            directed scenarios add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_clock_div;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b1;
  logic [WIDTH-1:0] div_in = '0;
  logic             div_load = 1'b0;
  logic             div_pending;
  logic [WIDTH-1:0] div_cur;
  logic             out;
  logic             tick;
  logic [CNT_W-1:0] tick_cnt;

  int checks = 0;
  int errors = 0;

  prog_clock_div #(.WIDTH(WIDTH), .DEFAULT_DIV(128), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .div_pending(div_pending), .div_cur(div_cur), .out(out), .tick(tick),
    .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_pos = 0, m_n = 128, m_pv = 0, m_tc = 0;
  bit m_pend = 0, m_out = 0, m_tick = 0, m_valid = 0;
  int prev_tc = 0;
  bit tc_wrapped = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int cl;
    bit old_tick;
    cl = (int'(div_in) < 2) ? 2 : int'(div_in);
    old_tick = m_tick;
    if (rst) begin
      m_pos = 0; m_n = 128; m_pend = 0; m_out = 0; m_tick = 0; m_tc = 0;
    end else if (en) begin
      if (m_pos == m_n - 1) begin
        m_pos = 0;
        if (div_load) begin m_n = cl; m_pend = 0; end
        else if (m_pend) begin m_n = m_pv; m_pend = 0; end
      end else begin
        m_pos++;
        if (div_load) begin m_pv = cl; m_pend = 1; end
      end
      m_out  = (m_pos >= m_n / 2);
      m_tick = (m_pos == m_n - 1);
      if (old_tick) m_tc = (m_tc + 1) % (1 << CNT_W);
    end else begin
      if (div_load) begin m_pv = cl; m_pend = 1; end
      else if (m_pend) begin m_n = m_pv; m_pend = 0; m_pos = 0; m_out = 0; end
      m_tick = 0;
    end
    m_valid = 1;
    #1;
    chk("out", int'(out), int'(m_out));
    chk("tick", int'(tick), int'(m_tick));
    chk("div_cur", int'(div_cur), m_n);
    chk("div_pending", int'(div_pending), int'(m_pend));
`ifdef PROG_CLOCK_DIV_TICK_CNT_EN
    chk("tick_cnt", int'(tick_cnt), m_tc);
`else
    chk("tick_cnt", int'(tick_cnt), 0);
`endif
    if (prev_tc == (1 << CNT_W) - 1 && int'(tick_cnt) == 0) tc_wrapped = 1;
    prev_tc = int'(tick_cnt);
  end

  // ---------------- directed stimulus ----------------
  task automatic strobe(input int v);
    div_in = WIDTH'(v);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (m_pos != p && n < 300) begin @(negedge clk); n++; end
    if (m_pos != p) chk("wait_pos_timeout", m_pos, p);
  endtask

  task automatic wait_applied();
    int n = 0;
    while (m_pend && n < 300) begin @(negedge clk); n++; end
    if (m_pend) chk("wait_apply_timeout", 1, 0);
  endtask

  task automatic window(input int cycles, output int ticks, output int highs);
    ticks = 0; highs = 0;
    repeat (cycles) begin
      @(negedge clk);
      ticks += int'(tick);
      highs += int'(out);
    end
  endtask

  initial begin
    int t, h;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_div_cur", int'(div_cur), 128);
    chk("rst_out", int'(out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_pending", int'(div_pending), 0);
    rst = 1'b0;

    // 1: default /128
    window(256, t, h);
    chk("n128_ticks", t, 2);
    chk("n128_highs", h, 128);

    // 2: load 5 mid-period
    wait_pos(40);
    strobe(5);
    chk("n5_pending", int'(div_pending), 1);
    chk("n5_cur_before_wrap", int'(div_cur), 128);
    wait_applied();
    chk("n5_cur", int'(div_cur), 5);
    window(15, t, h);
    chk("n5_ticks", t, 3);
    chk("n5_highs", h, 9);

    // 3: clamp of 0 and 1
    strobe(0);
    wait_applied();
    chk("clamp0_cur", int'(div_cur), 2);
    strobe(1);
    wait_applied();
    chk("clamp1_cur", int'(div_cur), 2);
    window(10, t, h);
    chk("n2_ticks", t, 5);
    chk("n2_highs", h, 5);

    // 4: last load wins; same-cycle load at wrap
    strobe(20);
    wait_applied();
    wait_pos(3);
    strobe(7);
    wait_pos(5);
    strobe(9);
    wait_applied();
    chk("last_wins_cur", int'(div_cur), 9);
    wait_pos(8);
    strobe(4);
    chk("same_cycle_cur", int'(div_cur), 4);
    chk("same_cycle_pending", int'(div_pending), 0);

    // 5: freeze, load while disabled, resume
    strobe(8);
    wait_applied();
    wait_pos(3);
    en = 1'b0;
    window(10, t, h);
    chk("frozen_ticks", t, 0);
    chk("frozen_highs", h, 0);
    strobe(6);
    chk("dis_pending", int'(div_pending), 1);
    @(negedge clk);
    chk("dis_apply_cur", int'(div_cur), 6);
    chk("dis_apply_out", int'(out), 0);
    chk("dis_apply_pending", int'(div_pending), 0);
    en = 1'b1;
    window(12, t, h);
    chk("n6_ticks", t, 2);
    chk("n6_highs", h, 6);

    // 6: reset with pending load
    strobe(128);
    wait_applied();
    wait_pos(50);
    strobe(10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_div_cur", int'(div_cur), 128);
    chk("rst2_pending", int'(div_pending), 0);
    chk("rst2_out", int'(out), 0);
    chk("rst2_tick_cnt", int'(tick_cnt), 0);
    strobe(2);
    wait_applied();
    repeat (600) @(negedge clk);
`ifdef PROG_CLOCK_DIV_TICK_CNT_EN
    chk("tick_cnt_wrapped", int'(tc_wrapped), 1);
`else
    chk("tick_cnt_tied", int'(tick_cnt), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
